alu_result_skid: RTL and testbench

Registered output stage that sits directly downstream of the 16-bit 4:1 ALU result mux. It captures each mux result together with the 2-bit select code that produced it, and derives zero and negative flags. It holds up to two results in a skid buffer, so the mux-side handshake runs at full throughput while the writeback consumer stalls. It also counts delivered results for bring-up visibility.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_flag_gen.sv | 24 ++
 rtl/alu_result_skid.sv | 148 ++++++++++++++
 tb/tb_alu_result_skid.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU result output stage.
//   ALU_W        : result width of the 4:1 ALU result mux.
//   skid_state_t : occupancy of the two-entry skid buffer.
//   alu_res_t    : one stored entry (result, select code and its flags).
// Optional feature macro: ADIA_ALU_PARITY_EN adds a per-entry parity bit.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic [1:0]       sel;
        logic             zero;
        logic             neg;
`ifdef ADIA_ALU_PARITY_EN
        logic             par;
`endif
    } alu_res_t;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational flag derivation for one ALU result.
// Ports:
//   data_i : result word
//   zero_o : data_i == 0
//   neg_o  : sign bit of data_i
//   par_o  : XOR-reduce of data_i (only with ADIA_ALU_PARITY_EN)
module alu_flag_gen #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
`ifdef ADIA_ALU_PARITY_EN
    output logic             par_o,
`endif
    output logic             zero_o,
    output logic             neg_o
);

    assign zero_o = (data_i == '0);
    assign neg_o  = data_i[WIDTH-1];
`ifdef ADIA_ALU_PARITY_EN
    assign par_o  = ^data_i;
`endif

endmodule

// File: rtl/alu_result_skid.sv
// alu_result_skid: registered two-entry skid stage behind the ALU result mux.
// Captures result + select code, derives zero/neg(/parity) flags on capture,
// and keeps the producer handshake at full rate while the consumer stalls.
// Ports:
//   clkpos, rst_n         : clock, asynchronous active-low reset
//   vdd, vss              : supply ties, no functional effect
//   in_valid/in_ready     : producer handshake; in_data, in_sel payload
//   out_valid/out_ready   : consumer handshake; out_data, out_sel, out_zero,
//                           out_neg, out_par (ADIA_ALU_PARITY_EN only)
//   res_count             : wrapping count of completed output transfers
// Optional feature macro: ADIA_ALU_PARITY_EN.
module alu_result_skid
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 16
) (
    input  logic             clkpos,
    input  logic             rst_n,
    input  logic             vdd,
    input  logic             vss,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ADIA_ALU_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] res_count
);

    skid_state_t      state_q;
    alu_res_t         main_q;
    alu_res_t         skid_q;
    alu_res_t         entry_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] res_count_q;
    logic             zero_d;
    logic             neg_d;
`ifdef ADIA_ALU_PARITY_EN
    logic             par_d;
`endif
    logic             in_xfer;
    logic             out_xfer;

    // Supply ties are carried for netlist consistency only.
    logic unused_supply;
    assign unused_supply = vdd ^ vss;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .data_i (in_data),
`ifdef ADIA_ALU_PARITY_EN
        .par_o  (par_d),
`endif
        .zero_o (zero_d),
        .neg_o  (neg_d)
    );

    always_comb begin
        entry_d      = '0;
        entry_d.data = in_data;
        entry_d.sel  = in_sel;
        entry_d.zero = zero_d;
        entry_d.neg  = neg_d;
`ifdef ADIA_ALU_PARITY_EN
        entry_d.par  = par_d;
`endif
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // in_ready/out_valid are registered from the next state, so in_ready
    // never depends combinationally on out_ready.
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_count_q <= '0;
        end else begin
            if (out_xfer) begin
                res_count_q <= res_count_q + 1'b1;
            end
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q      <= entry_d;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    case ({in_xfer, out_xfer})
                        2'b10: begin
                            skid_q     <= entry_d;
                            state_q    <= TWO;
                            in_ready_q <= 1'b0;
                        end
                        2'b01: begin
                            state_q     <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                        2'b11: begin
                            main_q <= entry_d;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_zero  = main_q.zero;
    assign out_neg   = main_q.neg;
`ifdef ADIA_ALU_PARITY_EN
    assign out_par   = main_q.par;
`endif
    assign res_count = res_count_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// tb_alu_result_skid: scoreboard bench for alu_result_skid.
// Stimulus pushes hand-computed expected entries when a result is accepted;
// a monitor branch pops and compares on every output transfer.
module tb_alu_result_skid;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  sel;
        logic        zero;
        logic        neg;
        logic        par;
    } exp_t;

    logic        clkpos = 1'b0;
    logic        rst_n  = 1'b0;
    logic        vdd    = 1'b1;
    logic        vss    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel  = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_zero;
    logic        out_neg;
`ifdef ADIA_ALU_PARITY_EN
    logic        out_par;
`endif
    logic [15:0] res_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] exp_cnt = '0;
    bit   stim_done = 0;

    always #5 clkpos = ~clkpos;

    alu_result_skid #(
        .WIDTH (16),
        .CNT_W (16)
    ) dut (
        .clkpos    (clkpos),
        .rst_n     (rst_n),
        .vdd       (vdd),
        .vss       (vss),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`ifdef ADIA_ALU_PARITY_EN
        .out_par   (out_par),
`endif
        .res_count (res_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [1:0] s, input logic z,
                        input logic n, input logic p, output int waits);
        exp_t e;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clkpos);
            if (in_ready) begin
                e.data = d; e.sel = s; e.zero = z; e.neg = n; e.par = p;
                sb.push_back(e);
                @(posedge clkpos);
                #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            if (waits > 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout data=%h in_ready stuck low", d);
                in_valid = 1'b0;
                return;
            end
            @(posedge clkpos);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 40) begin
            @(negedge clkpos);
            n++;
        end
        @(posedge clkpos);
        #1;
        chk("drain_empty", sb.size(), 0);
        chk("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        fork
            begin : stimulus
                int w;
                // reset state
                #7;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_sel", out_sel, 0);
                chk("rst_flags", {out_zero, out_neg}, 0);
                chk("rst_count", res_count, 0);
                @(posedge clkpos); #1;
                rst_n = 1'b1;
                @(posedge clkpos); #1;

                // zero result, latency from EMPTY
                out_ready = 1'b1;
                send(16'h0000, 2'b10, 1'b1, 1'b0, 1'b0, w);
                @(negedge clkpos);
                chk("latency_out_valid", out_valid, 1);
                chk("latency_out_zero", out_zero, 1);
                @(posedge clkpos); #1;
                @(negedge clkpos);
                chk("count_after_first", res_count, 1);
                @(posedge clkpos); #1;

                // back-to-back at full rate
                send(16'h8001, 2'b01, 1'b0, 1'b1, 1'b0, w);
                chk("b2b_ready_1", w, 0);
                send(16'h0003, 2'b11, 1'b0, 1'b0, 1'b0, w);
                chk("b2b_ready_2", w, 0);
                send(16'h7FFF, 2'b00, 1'b0, 1'b0, 1'b1, w);
                chk("b2b_ready_3", w, 0);
                drain();

                // consumer stall: fill both entries
                out_ready = 1'b0;
                send(16'h8001, 2'b01, 1'b0, 1'b1, 1'b0, w);
                chk("stall_acc_1", w, 0);
                send(16'h0003, 2'b11, 1'b0, 1'b0, 1'b0, w);
                chk("stall_acc_2", w, 0);
                in_data  = 16'h7FFF;
                in_sel   = 2'b00;
                in_valid = 1'b1;
                @(negedge clkpos);
                chk("stall_ready_low", in_ready, 0);
                chk("stall_hold_data", out_data, 16'h8001);
                @(posedge clkpos); #1;
                out_ready = 1'b1;
                @(negedge clkpos);
                chk("two_not_accepted", in_ready, 0);
                @(posedge clkpos);
                @(negedge clkpos);
                chk("skid_to_main", out_data, 16'h0003);
                chk("one_ready", in_ready, 1);
                begin
                    exp_t e;
                    e.data = 16'h7FFF; e.sel = 2'b00; e.zero = 1'b0; e.neg = 1'b0; e.par = 1'b1;
                    sb.push_back(e);
                end
                @(posedge clkpos); #1;
                in_valid = 1'b0;
                drain();

                // reset while holding two entries
                out_ready = 1'b0;
                send(16'h1111, 2'b01, 1'b0, 1'b0, 1'b0, w);
                send(16'h2222, 2'b10, 1'b0, 1'b0, 1'b0, w);
                #1;
                rst_n = 1'b0;
                #1;
                chk("midrst_out_valid", out_valid, 0);
                chk("midrst_count", res_count, 0);
                chk("midrst_in_ready", in_ready, 1);
                chk("midrst_out_data", out_data, 0);
                @(posedge clkpos); @(posedge clkpos); #1;
                rst_n = 1'b1;
                @(posedge clkpos); #1;
                out_ready = 1'b1;
                send(16'h5A5A, 2'b11, 1'b0, 1'b0, 1'b0, w);
                @(negedge clkpos);
                chk("post_rst_data", out_data, 16'h5A5A);
                @(posedge clkpos); #1;
                send(16'h0007, 2'b01, 1'b0, 1'b0, 1'b1, w);
                drain();

                // counter wrap: two transfers so far
                for (int i = 0; i < 65533; i++) begin
                    send(16'h1234, 2'b10, 1'b0, 1'b0, 1'b1, w);
                end
                drain();
                chk("count_ffff", res_count, 16'hFFFF);
                send(16'hF000, 2'b00, 1'b0, 1'b1, 1'b0, w);
                drain();
                chk("count_wrap", res_count, 16'h0000);
                stim_done = 1;
            end
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clkpos);
                    if (!rst_n) begin
                        sb.delete();
                        exp_cnt = '0;
                    end else if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL out_unexpected got data=%h sel=%b", out_data, out_sel);
                        end else begin
                            e = sb.pop_front();
                            if (out_data !== e.data || out_sel !== e.sel ||
                                out_zero !== e.zero || out_neg !== e.neg
`ifdef ADIA_ALU_PARITY_EN
                                || out_par !== e.par
`endif
                                ) begin
                                errors++;
                                $display("FAIL out_entry got data=%h sel=%b z=%b n=%b exp data=%h sel=%b z=%b n=%b p=%b",
                                         out_data, out_sel, out_zero, out_neg,
                                         e.data, e.sel, e.zero, e.neg, e.par);
                            end
                        end
                        checks++;
                        if (res_count !== exp_cnt) begin
                            errors++;
                            $display("FAIL out_count got=%h exp=%h", res_count, exp_cnt);
                        end
                        exp_cnt = exp_cnt + 16'd1;
                    end
                end
            end
            begin : watchdog
                #2000000;
                checks++;
                errors++;
                $display("FAIL watchdog time limit reached");
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
